// File: rtl/matrix_stream_parser.sv
// ASCII decimal token parser: dimension header, then element writes into
// matrix storage, with zero padding of missing elements after an idle timeout.
module matrix_stream_parser #(
    parameter int ELEM_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int MAX_VAL = 9,
    parameter int MAX_CNT = 2,
    parameter int TIMEOUT = 500000
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ELEM_W-1:0] wr_data,
    output logic [2:0]        dim_rows,
    output logic [2:0]        dim_cols,
    output logic [ELEM_W-1:0] gen_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ROW  = 3'd1;
    localparam logic [2:0] S_COL  = 3'd2;
    localparam logic [2:0] S_CNT  = 3'd3;
    localparam logic [2:0] S_ELEM = 3'd4;
    localparam logic [2:0] S_PAD  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = ELEM_W + 4;
    localparam logic [ELEM_W-1:0] ACC_MAX = '1;
    localparam logic [ELEM_W-1:0] VMAX = ELEM_W'(MAX_VAL);

    logic [2:0]        state_q, state_d;
    logic [ELEM_W-1:0] acc_q, acc_d;
    logic              pend_q, pend_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [4:0]        idx_q, idx_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        rows_q, rows_d;
    logic [2:0]        cols_q, cols_d;
    logic [ELEM_W-1:0] gen_q, gen_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ELEM_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              is_digit, is_delim, parsing, tok_done, last, dim_ok, cnt_ok;
    logic              timeout_hit;
    logic [AW-1:0]     acc_ext;
    logic [ELEM_W-1:0] acc_next;
    logic [5:0]        total;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_delim = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign parsing  = (state_q == S_ROW) || (state_q == S_COL) ||
                      (state_q == S_CNT) || (state_q == S_ELEM);
    assign acc_ext  = {4'b0, acc_q} * AW'(10) + AW'(rx_data[3:0]);
    assign acc_next = (acc_ext > AW'(ACC_MAX)) ? ACC_MAX : acc_ext[ELEM_W-1:0];
    assign tok_done = parsing && rx_valid && is_delim && pend_q;
    assign total    = {3'b0, rows_q} * {3'b0, cols_q};
    assign last     = (6'(idx_q) + 6'd1) == total;
    assign dim_ok   = (acc_q >= ELEM_W'(1)) && (acc_q <= ELEM_W'(MAX_DIM));
    assign cnt_ok   = (acc_q >= ELEM_W'(1)) && (acc_q <= ELEM_W'(MAX_CNT));
    // A byte in the expiry cycle takes priority and restarts the idle count
    assign timeout_hit = (state_q == S_ELEM) && !rx_valid &&
                         (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        pend_d     = pend_q;
        mode_d     = mode_q;
        base_d     = base_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        gen_d      = gen_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        if (parsing && rx_valid) begin
            acc_d  = is_digit ? acc_next : '0;
            pend_d = is_digit;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ROW;
                    base_d     = base_addr;
                    mode_d     = mode;
                    acc_d      = '0;
                    pend_d     = 1'b0;
                    idx_d      = '0;
                    timer_d    = '0;
                    rows_d     = '0;
                    cols_d     = '0;
                    gen_d      = '0;
                    err_code_d = 2'd0;
                end
            end
            S_ROW, S_COL: begin
                if (tok_done) begin
                    if (!dim_ok) begin
                        state_d    = S_ROW;
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                    end else if (state_q == S_ROW) begin
                        rows_d  = acc_q[2:0];
                        state_d = S_COL;
                    end else begin
                        cols_d  = acc_q[2:0];
                        idx_d   = '0;
                        timer_d = '0;
                        state_d = mode_q ? S_CNT : S_ELEM;
                    end
                end
            end
            S_CNT: begin
                if (tok_done) begin
                    if (cnt_ok) begin
                        gen_d   = acc_q;
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ROW;
                        err_d      = 1'b1;
                        err_code_d = 2'd3;
                    end
                end
            end
            S_ELEM: begin
                timer_d = rx_valid ? '0 : timer_q + TW'(1);
                if (tok_done || (timeout_hit && pend_q)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + ADDR_W'(idx_q);
                    wr_data_d = (acc_q > VMAX) ? VMAX : acc_q;
                    if (acc_q > VMAX) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                    end
                    if (timeout_hit) begin
                        acc_d  = '0;
                        pend_d = 1'b0;
                    end
                    if (last) state_d = S_DONE;
                    else begin
                        idx_d = idx_q + 5'd1;
                        if (timeout_hit) state_d = S_PAD;
                    end
                end else if (timeout_hit) begin
                    state_d = S_PAD;
                end
            end
            S_PAD: begin
                wr_en_d   = 1'b1;
                wr_addr_d = base_q + ADDR_W'(idx_q);
                wr_data_d = '0;
                if (last) state_d = S_DONE;
                else idx_d = idx_q + 5'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            pend_q     <= 1'b0;
            mode_q     <= 1'b0;
            base_q     <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            gen_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            pend_q     <= pend_d;
            mode_q     <= mode_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            gen_q      <= gen_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign dim_rows  = rows_q;
    assign dim_cols  = cols_q;
    assign gen_count = gen_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_matrix_stream_parser.sv
// Bench for matrix_stream_parser: directed and random byte streams checked
// against a token-level reference model of the parser.
module tb_matrix_stream_parser;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       sys_rst, start, mode, rx_valid;
    logic [7:0] base_addr, rx_data, wr_addr, wr_data, gen_count;
    logic       wr_en, busy, done, err;
    logic [2:0] dim_rows, dim_cols;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    matrix_stream_parser #(.TIMEOUT(TO)) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start), .mode(mode),
        .base_addr(base_addr), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dim_rows(dim_rows), .dim_cols(dim_cols), .gen_count(gen_count),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] got_w[$];
    logic [1:0]  got_e[$];
    int          done_cnt;

    logic [7:0]  stim[$];
    logic [15:0] exp_w[$];
    logic [1:0]  exp_e[$];
    bit          exp_done;
    int          exp_rows, exp_cols, exp_gen;

    always @(negedge clk) begin
        if (wr_en) got_w.push_back({wr_addr, wr_data});
        if (err) got_e.push_back(err_code);
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic put_elem(input int v, input logic [7:0] addr);
        exp_w.push_back({addr, (v > 9) ? 8'd9 : 8'(v)});
        if (v > 9) exp_e.push_back(2'd2);
    endtask

    // Phases: 0 rows, 1 cols, 2 count, 3 elements, 4 finished
    task automatic model(input bit md, input logic [7:0] base);
        int ph, acc, rows, cols, idx, tok;
        bit pend;
        logic [7:0] b;
        ph = 0; acc = 0; rows = 0; cols = 0; idx = 0; pend = 0;
        exp_w.delete(); exp_e.delete();
        exp_rows = 0; exp_cols = 0; exp_gen = 0;
        for (int i = 0; i < stim.size(); i++) begin
            b = stim[i];
            if (ph == 4) break;
            if (b >= 8'h30 && b <= 8'h39) begin
                acc = acc * 10 + int'(b - 8'h30);
                if (acc > 255) acc = 255;
                pend = 1;
            end else if (b == 8'h20 || b == 8'h0D || b == 8'h0A) begin
                if (pend) begin
                    tok = acc; acc = 0; pend = 0;
                    case (ph)
                        0: if (tok >= 1 && tok <= 5) begin rows = tok; exp_rows = tok; ph = 1; end
                           else exp_e.push_back(2'd1);
                        1: if (tok >= 1 && tok <= 5) begin cols = tok; exp_cols = tok; ph = md ? 2 : 3; end
                           else begin exp_e.push_back(2'd1); ph = 0; end
                        2: if (tok >= 1 && tok <= 2) begin exp_gen = tok; ph = 4; end
                           else begin exp_e.push_back(2'd3); ph = 0; end
                        default: begin
                            put_elem(tok, 8'(base + idx));
                            idx++;
                            if (idx == rows * cols) ph = 4;
                        end
                    endcase
                end
            end else begin
                acc = 0; pend = 0;
            end
        end
        if (ph == 3) begin
            if (pend) begin put_elem(acc, 8'(base + idx)); idx++; end
            while (idx < rows * cols) begin put_elem(0, 8'(base + idx)); idx++; end
            ph = 4;
        end
        exp_done = (ph == 4);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run(input string tag, input bit md, input logic [7:0] base, input bit poke);
        int t;
        model(md, base);
        got_w.delete(); got_e.delete(); done_cnt = 0;
        @(negedge clk);
        start = 1'b1; mode = md; base_addr = base;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < stim.size(); i++) begin
            if (poke && i == stim.size() / 2) begin
                start = 1'b1; base_addr = 8'hAA; mode = ~md;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(stim[i], $urandom_range(0, 2));
        end
        t = 0;
        if (exp_done) begin
            while (done_cnt == 0 && t < 3 * TO + 200) begin @(negedge clk); t++; end
            repeat (4) @(negedge clk);
        end else begin
            repeat (3 * TO) @(negedge clk);
        end
        check({tag, ".done"}, done_cnt, exp_done ? 1 : 0);
        check({tag, ".nwr"}, got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            check($sformatf("%s.wr%0d", tag, i), got_w[i], exp_w[i]);
        check({tag, ".nerr"}, got_e.size(), exp_e.size());
        for (int i = 0; i < exp_e.size() && i < got_e.size(); i++)
            check($sformatf("%s.err%0d", tag, i), got_e[i], exp_e[i]);
        check({tag, ".rows"}, dim_rows, exp_rows);
        check({tag, ".cols"}, dim_cols, exp_cols);
        check({tag, ".gen"}, gen_count, exp_gen);
        check({tag, ".busy"}, busy, exp_done ? 0 : 1);
        if (!exp_done) begin
            @(negedge clk); sys_rst = 1'b1;
            @(negedge clk); sys_rst = 1'b0;
        end
    endtask

    function automatic int pick_val();
        int r;
        r = $urandom % 10;
        if (r < 7) return $urandom_range(0, 6);
        if (r < 9) return $urandom_range(7, 15);
        return $urandom_range(100, 999);
    endfunction

    function automatic string pick_delim();
        int r;
        r = $urandom % 3;
        if (r == 0) return "\r";
        if (r == 1) return "\n";
        return " ";
    endfunction

    initial begin
        sys_rst = 1'b1; start = 1'b0; mode = 1'b0;
        base_addr = '0; rx_data = '0; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.outs", {wr_en, wr_addr, wr_data, dim_rows, dim_cols,
                             gen_count, busy, done, err, err_code}, 64'd0);
        sys_rst = 1'b0;

        stim.delete(); push_str("2 3 4 5 6 7 8 9 ");
        run("m0_basic", 1'b0, 8'd0, 1'b1);
        stim.delete(); push_str("1 4 1 2 3 4 5 ");
        run("m0_extra", 1'b0, 8'd16, 1'b0);
        stim.delete(); push_str("1 4 1 2 3 ");
        run("m0_timeout", 1'b0, 8'd12, 1'b0);
        stim.delete(); push_str("1 4 1 2 3");
        run("m0_tmo_pend", 1'b0, 8'd252, 1'b0);
        stim.delete(); push_str("6 1 4 1 3 4 5 6 ");
        run("m0_baddim", 1'b0, 8'd32, 1'b0);
        stim.delete(); push_str("2 3 2 ");
        run("m1_ok", 1'b1, 8'd0, 1'b0);
        stim.delete(); push_str("2 3 7 ");
        run("m1_badcnt", 1'b1, 8'd0, 1'b0);
        stim.delete(); push_str("1 1 12 ");
        run("m0_bigval", 1'b0, 8'd40, 1'b0);
        stim.delete(); push_str("\r\n2x 1\n1 999\r");
        run("m0_junk_sat", 1'b0, 8'd7, 1'b0);

        @(negedge clk);
        start = 1'b1; mode = 1'b0; base_addr = 8'd5;
        @(negedge clk);
        start = 1'b0;
        stim.delete(); push_str("1 3 1 2 ");
        for (int i = 0; i < stim.size(); i++) send_byte(stim[i], 0);
        @(negedge clk); sys_rst = 1'b1;
        @(negedge clk); sys_rst = 1'b0;
        check("midrst.outs", {wr_en, wr_addr, wr_data, dim_rows, dim_cols,
                              gen_count, busy, done, err, err_code}, 64'd0);
        got_w.delete(); done_cnt = 0;
        stim.delete(); push_str("3 4 5 ");
        for (int i = 0; i < stim.size(); i++) send_byte(stim[i], 0);
        repeat (3 * TO) @(negedge clk);
        check("midrst.nwr", got_w.size(), 0);
        check("midrst.done", done_cnt, 0);

        for (int n = 0; n < 30; n++) begin
            int k;
            stim.delete();
            k = $urandom_range(2, 12);
            for (int j = 0; j < k; j++) begin
                push_str($sformatf("%0d", pick_val()));
                if ($urandom % 12 == 0) push_str("a");
                push_str(pick_delim());
                if ($urandom % 10 == 0) push_str(pick_delim());
            end
            if ($urandom % 4 == 0) push_str($sformatf("%0d", pick_val()));
            run($sformatf("rnd%0d", n), 1'($urandom % 2), 8'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
